result_writeback: RTL and testbench

Drains finished result tiles from the matrix unit's accumulated-output tile FIFO and writes them element by element into a word-addressed result memory. It is the consumer side of the output FIFO's pop interface and sits between the matrix unit and the result/unified buffer. Optionally, it sums several consecutive result tiles into one before writing, which supports K-blocked multiplications.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/tile_accumulator.sv | 38 +++
 rtl/result_writeback.sv | 180 ++++++++++++++++++
 tb/tb_result_writeback.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared matrix-unit types: writeback FSM states and accumulator element width.
// No logic; imported by the writeback datapath.
// No flow control of its own.
package tpu_pkg;

    localparam int TILE_ACC_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        WRITE,
        DONE
    } wb_state_t;

endpackage

// File: rtl/tile_accumulator.sv
// SIZE x SIZE tile register that either loads a new tile or adds it elementwise.
// One cycle: tile_d is combinational, tile_q updates on the clock edge when en=1.
// No backpressure; the caller decides when to enable.
module tile_accumulator
    import tpu_pkg::*;
#(
    parameter int SIZE = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     en,
    input  logic                                     add,
    input  logic [SIZE-1:0][SIZE-1:0][TILE_ACC_W-1:0] din,
    output logic [SIZE-1:0][SIZE-1:0][TILE_ACC_W-1:0] tile_d,
    output logic [SIZE-1:0][SIZE-1:0][TILE_ACC_W-1:0] tile_q
);

    // Sums wrap at 32 bits; no saturation.
    always_comb begin
        tile_d = din;
        if (add) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    tile_d[r][c] = tile_q[r][c] + din[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q <= '0;
        end else if (en) begin
            tile_q <= tile_d;
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Pops result tiles from the output FIFO and writes them row-major into result memory;
// ACC_ACCUM_EN sums k_tiles FIFO tiles per output tile. Latency: 2 + SIZE^2 cycles per tile.
// Backpressure: waits in POP while acc_in_rdy=0, holds each write until wr_rdy=1.
module result_writeback
    import tpu_pkg::*;
#(
    parameter int SIZE   = 2,
    parameter int ADDR_W = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [SIZE-1:0][SIZE-1:0][TILE_ACC_W-1:0] acc_in,
    input  logic                                     acc_in_rdy,
    output logic                                     acc_in_pop,
    input  logic                                     start,
    input  logic [ADDR_W-1:0]                        base_addr,
    input  logic [15:0]                              num_tiles,
    input  logic [7:0]                               k_tiles,
    output logic                                     wr_en,
    output logic [ADDR_W-1:0]                        wr_addr,
    output logic [TILE_ACC_W-1:0]                    wr_data,
    input  logic                                     wr_rdy,
    output logic                                     busy,
    output logic                                     done
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(SIZE - 1);

    typedef logic [SIZE-1:0][SIZE-1:0][TILE_ACC_W-1:0] tile_t;

    wb_state_t         state;
    tile_t             tile_q;
    tile_t             tile_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       num_q;
    logic [15:0]       out_idx;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     c_idx;
    logic [IW-1:0]     r_nx;
    logic [IW-1:0]     c_nx;
    logic              last_elem;
    logic              grp_done;
    logic              tile_en;

    assign acc_in_pop = (state == POP) && acc_in_rdy;
    assign tile_en    = (state == LATCH);
    assign last_elem  = (r_idx == IDX_LAST) && (c_idx == IDX_LAST);

    always_comb begin
        r_nx = r_idx;
        c_nx = c_idx + IW'(1);
        if (c_idx == IDX_LAST) begin
            c_nx = '0;
            r_nx = r_idx + IW'(1);
        end
    end

`ifdef ACC_ACCUM_EN
    logic [7:0] k_cnt;
    logic [7:0] k_last;

    assign grp_done = (k_cnt == k_last);

    tile_accumulator #(
        .SIZE (SIZE)
    ) u_tile_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tile_en),
        .add    (k_cnt != 8'd0),
        .din    (acc_in),
        .tile_d (tile_d),
        .tile_q (tile_q)
    );
`else
    logic [7:0] unused_k_tiles;

    assign unused_k_tiles = k_tiles;
    assign grp_done       = 1'b1;
    assign tile_d         = acc_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q <= '0;
        end else if (tile_en) begin
            tile_q <= acc_in;
        end
    end
`endif

    // addr_q tracks the address of the element currently (or next) on the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            num_q   <= '0;
            out_idx <= '0;
            r_idx   <= '0;
            c_idx   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef ACC_ACCUM_EN
            k_cnt   <= '0;
            k_last  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        num_q   <= num_tiles;
                        out_idx <= '0;
                        busy    <= 1'b1;
`ifdef ACC_ACCUM_EN
                        k_cnt   <= '0;
                        k_last  <= (k_tiles == 8'd0) ? 8'd0 : k_tiles - 8'd1;
`endif
                        if (num_tiles == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= POP;
                        end
                    end
                end
                POP: begin
                    if (acc_in_rdy) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
`ifdef ACC_ACCUM_EN
                    k_cnt <= grp_done ? 8'd0 : k_cnt + 8'd1;
`endif
                    if (grp_done) begin
                        state   <= WRITE;
                        r_idx   <= '0;
                        c_idx   <= '0;
                        wr_en   <= 1'b1;
                        wr_addr <= addr_q;
                        wr_data <= tile_d[0][0];
                    end else begin
                        state <= POP;
                    end
                end
                WRITE: begin
                    if (wr_rdy) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (last_elem) begin
                            wr_en   <= 1'b0;
                            out_idx <= out_idx + 16'd1;
                            if (out_idx + 16'd1 == num_q) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= POP;
                            end
                        end else begin
                            r_idx   <= r_nx;
                            c_idx   <= c_nx;
                            wr_addr <= addr_q + ADDR_W'(1);
                            wr_data <= tile_q[r_nx][c_nx];
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: FIFO model, write-port monitor, hand-computed vectors.
module tb_result_writeback;

    typedef logic [1:0][1:0][31:0] tile_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tile_t       acc_in = '0;
    logic        acc_in_rdy = 1'b1;
    logic        acc_in_pop;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] num_tiles = '0;
    logic [7:0]  k_tiles = '0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_rdy = 1'b1;
    logic        busy;
    logic        done;

    result_writeback #(.SIZE(2), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_in     (acc_in),
        .acc_in_rdy (acc_in_rdy),
        .acc_in_pop (acc_in_pop),
        .start      (start),
        .base_addr  (base_addr),
        .num_tiles  (num_tiles),
        .k_tiles    (k_tiles),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_rdy     (wr_rdy),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 1 << 30;
    int ws_from = -100, ws_len = 0;
    int as_from = -100, as_len = 0;

    tile_t       fifo_q[$];
    logic [15:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          pops, done_cnt, done_cyc, first_pop, first_busy, last_busy;
    logic        en_h[256];
    logic [15:0] addr_h[256];
    logic [31:0] data_h[256];

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: popped tile appears on acc_in the cycle after the pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_in <= '0;
        end else if (acc_in_pop && fifo_q.size() > 0) begin
            acc_in <= fifo_q.pop_front();
        end
    end

    always @(posedge clk) begin
        int r;
        #2;
        r = cyc - t0;
        wr_rdy     = !(r >= ws_from && r < ws_from + ws_len);
        acc_in_rdy = !(r >= as_from && r < as_from + as_len);
    end

    always @(negedge clk) begin
        int rel;
        if (rst_n) begin
            rel = cyc - t0;
            if (rel >= 0 && rel < 256) begin
                en_h[rel]   = wr_en;
                addr_h[rel] = wr_addr;
                data_h[rel] = wr_data;
            end
            if (wr_en && wr_rdy) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
                wq_cyc.push_back(rel);
            end
            if (acc_in_pop) begin
                pops++;
                if (first_pop < 0) first_pop = rel;
            end
            if (done) begin
                done_cnt++;
                done_cyc = rel;
            end
            if (busy) begin
                if (first_busy < 0) first_busy = rel;
                last_busy = rel;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic tile_t mk(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d);
        tile_t t;
        t[0][0] = a;
        t[0][1] = b;
        t[1][0] = c;
        t[1][1] = d;
        return t;
    endfunction

    // Called aligned to posedge+1; leaves the bench in cycle 1 of the job.
    task automatic start_job(input logic [15:0] base, input logic [15:0] n, input logic [7:0] k);
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        pops = 0;
        done_cnt = 0;
        done_cyc = -1;
        first_pop = -1;
        first_busy = -1;
        last_busy = -1;
        for (int i = 0; i < 256; i++) en_h[i] = 1'b0;
        base_addr = base;
        num_tiles = n;
        k_tiles   = k;
        start     = 1'b1;
        t0        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("done_count", done_cnt, 1);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [15:0] a,
                            input logic [31:0] d, input int c);
        if (idx >= wq_addr.size()) begin
            check({tag, "_present"}, wq_addr.size(), idx + 1);
        end else begin
            check({tag, "_addr"}, wq_addr[idx], a);
            check({tag, "_data"}, wq_data[idx], d);
            if (c >= 0) check({tag, "_cycle"}, wq_cyc[idx], c);
        end
    endtask

    task automatic clear_stalls();
        ws_from = -100;
        ws_len  = 0;
        as_from = -100;
        as_len  = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pop", acc_in_pop, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single tile, no stalls: writes in cycles 3..6, done in 7, busy 1..7.
        fifo_q.push_back(mk(1, 2, 3, 4));
        start_job(16'h0010, 1, 0);
        wait_done(60);
        check("t1_nwr", wq_addr.size(), 4);
        for (int i = 0; i < 4; i++) check_wr("t1_w", i, 16'h10 + 16'(i), 32'(i + 1), 3 + i);
        check("t1_done_cyc", done_cyc, 7);
        check("t1_pops", pops, 1);
        check("t1_busy_first", first_busy, 1);
        check("t1_busy_last", last_busy, 7);

        // Three tiles back to back: 6 cycles each, done in cycle 19.
        fifo_q.push_back(mk(1, 2, 3, 4));
        fifo_q.push_back(mk(5, 6, 7, 8));
        fifo_q.push_back(mk(9, 10, 11, 12));
        start_job(16'h0010, 3, 0);
        wait_done(100);
        check("t2_nwr", wq_addr.size(), 12);
        for (int i = 0; i < 12; i++) check_wr("t2_w", i, 16'h10 + 16'(i), 32'(i + 1), -1);
        check("t2_pops", pops, 3);
        check("t2_done_cyc", done_cyc, 19);

        // wr_rdy low in cycles 4-5 while element 1 is offered.
        fifo_q.push_back(mk(1, 2, 3, 4));
        ws_from = 4;
        ws_len  = 2;
        start_job(16'h0010, 1, 0);
        wait_done(60);
        clear_stalls();
        check("t3_nwr", wq_addr.size(), 4);
        check_wr("t3_w0", 0, 16'h10, 1, 3);
        check_wr("t3_w1", 1, 16'h11, 2, 6);
        check_wr("t3_w2", 2, 16'h12, 3, 7);
        check_wr("t3_w3", 3, 16'h13, 4, 8);
        check("t3_hold_en", {en_h[4], en_h[5]}, 2'b11);
        check("t3_hold_addr", {addr_h[4], addr_h[5]}, {16'h11, 16'h11});
        check("t3_hold_data", {data_h[4], data_h[5]}, {32'd2, 32'd2});
        check("t3_done_cyc", done_cyc, 9);

        // FIFO empty for cycles 1-5: pop in 6, writes from 8, done in 12.
        fifo_q.push_back(mk(21, 22, 23, 24));
        as_from = 1;
        as_len  = 5;
        start_job(16'h0040, 1, 0);
        wait_done(60);
        clear_stalls();
        check("t4_first_pop", first_pop, 6);
        check("t4_pops", pops, 1);
        check_wr("t4_w0", 0, 16'h40, 21, 8);
        check_wr("t4_w3", 3, 16'h43, 24, 11);
        check("t4_done_cyc", done_cyc, 12);

        // num_tiles = 0: straight to DONE.
        start_job(16'h0010, 0, 0);
        wait_done(20);
        check("t5_done_cyc", done_cyc, 1);
        check("t5_pops", pops, 0);
        check("t5_nwr", wq_addr.size(), 0);
        check("t5_busy_last", last_busy, 1);

        // Address wraps modulo 2^16.
        fifo_q.push_back(mk(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003));
        start_job(16'hFFFE, 1, 0);
        wait_done(60);
        check_wr("t6_w1", 1, 16'hFFFF, 32'hDEAD0001, 4);
        check_wr("t6_w2", 2, 16'h0000, 32'hDEAD0002, 5);
        check_wr("t6_w3", 3, 16'h0001, 32'hDEAD0003, 6);

`ifdef ACC_ACCUM_EN
        // k_tiles=2: two pops summed per output tile; done at 1 + 2*2 + 4 = 9.
        fifo_q.push_back(mk(1, 2, 3, 4));
        fifo_q.push_back(mk(10, 20, 30, 40));
        start_job(16'h0020, 1, 2);
        wait_done(60);
        check("t7_pops", pops, 2);
        check_wr("t7_w0", 0, 16'h20, 11, 5);
        check_wr("t7_w1", 1, 16'h21, 22, 6);
        check_wr("t7_w2", 2, 16'h22, 33, 7);
        check_wr("t7_w3", 3, 16'h23, 44, 8);
        check("t7_done_cyc", done_cyc, 9);

        fifo_q.push_back(mk(32'h7FFFFFFF, 5, 32'hFFFFFFFF, 0));
        fifo_q.push_back(mk(1, 6, 1, 0));
        start_job(16'h0030, 1, 2);
        wait_done(60);
        check("t8_pops", pops, 2);
        check_wr("t8_w0", 0, 16'h30, 32'h80000000, -1);
        check_wr("t8_w1", 1, 16'h31, 11, -1);
        check_wr("t8_w2", 2, 16'h32, 0, -1);

        // k_tiles=0 behaves as 1.
        fifo_q.push_back(mk(7, 8, 9, 10));
        start_job(16'h0050, 1, 0);
        wait_done(60);
        check("t9_pops", pops, 1);
        check_wr("t9_w0", 0, 16'h50, 7, 3);
`else
        // k_tiles has no effect: one pop per output tile.
        fifo_q.push_back(mk(1, 2, 3, 4));
        fifo_q.push_back(mk(10, 20, 30, 40));
        start_job(16'h0020, 1, 2);
        wait_done(60);
        check("t7_pops", pops, 1);
        check_wr("t7_w0", 0, 16'h20, 1, 3);
        check_wr("t7_w3", 3, 16'h23, 4, 6);
        check("t7_done_cyc", done_cyc, 7);
        fifo_q.delete();
`endif

        // Reset during the third write, then a fresh job from address 0.
        fifo_q.push_back(mk(1, 2, 3, 4));
        start_job(16'h0010, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t10_pre_en", wr_en, 1);
        check("t10_pre_addr", wr_addr, 16'h12);
        rst_n = 1'b0;
        #1;
        check("t10_rst_outs", {wr_en, busy, done, acc_in_pop}, 4'b0000);
        check("t10_rst_addr", wr_addr, 0);
        check("t10_rst_data", wr_data, 0);
        @(posedge clk);
        #1;
        check("t10_rst_hold", {wr_en, busy, done}, 3'b000);
        rst_n = 1'b1;
        fifo_q.delete();
        @(posedge clk);
        #1;
        fifo_q.push_back(mk(5, 6, 7, 8));
        start_job(16'h0000, 1, 0);
        wait_done(60);
        check("t10_nwr", wq_addr.size(), 4);
        for (int i = 0; i < 4; i++) check_wr("t10_w", i, 16'(i), 32'(i + 5), 3 + i);
        check("t10_pops", pops, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
